// File: rtl/mux_fault_diagnoser_if.sv
// Signal bundle between the mux fault diagnoser and the 2:1 mux under test.
// The slave side is the diagnoser. The master side is the harness or the mux.
interface mux_fault_diagnoser_if;
    logic       start;
    logic       s_out;
    logic       i0_out;
    logic       i1_out;
    logic [8:0] obs;
    logic       busy;
    logic       done;
    logic [8:0] candidates;
    logic [3:0] err_count;
    logic       fault_seen;

    modport master (
        output start, obs,
        input  s_out, i0_out, i1_out, busy, done, candidates, err_count, fault_seen
    );

    modport slave (
        input  start, obs,
        output s_out, i0_out, i1_out, busy, done, candidates, err_count, fault_seen
    );
endinterface

// File: rtl/mux_fault_diagnoser.sv
// Steps the mux under test through all eight input vectors and checks its wires against golden values.
// On every mismatching vector, the candidate fault-location mask is narrowed.
module mux_fault_diagnoser #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux_fault_diagnoser_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] k;
    logic [3:0] cnt;
    logic       s_q, i0_q, i1_q;
    logic       busy_q, done_q;
    logic [8:0] candidates_q;
    logic [3:0] err_count_q;

    logic [8:0] diff;
    logic [8:0] narrowed;

    // The wire order is {g8..g0}. g8 is the mux output, and g6/g7 are its AND terms.
    function automatic logic [8:0] golden(input logic s, input logic i0, input logic i1);
        return {(i1 & s) | (i0 & ~s), i0 & ~s, i1 & s, ~s, s, s, s, i1, i0};
    endfunction

    function automatic logic [8:0] weight(input logic [3:0] idx);
        case (idx)
            4'd0:    return 9'b100000000;
            4'd1:    return 9'b010000000;
            4'd2:    return 9'b001000000;
            4'd3:    return 9'b001100000;
            4'd4:    return 9'b001010000;
            4'd5:    return 9'b001011000;
            4'd6:    return 9'b011100100;
            4'd7:    return 9'b101011010;
            default: return 9'b111111111;
        endcase
    endfunction

    function automatic logic [3:0] highest_bit(input logic [8:0] d);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (d[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        diff     = bus.obs ^ golden(s_q, i0_q, i1_q);
        narrowed = candidates_q & weight(highest_bit(diff));
    end

    // NOTE: state is updated with non-blocking assignments only. Every register then sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= 3'd0;
            cnt          <= 4'd0;
            s_q          <= 1'b0;
            i0_q         <= 1'b0;
            i1_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            candidates_q <= 9'h1FF;
            err_count_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        candidates_q       <= 9'h1FF;
                        err_count_q        <= 4'd0;
                        k                  <= 3'd0;
                        {i0_q, i1_q, s_q}  <= 3'd0;
                        cnt                <= 4'd0;
                        busy_q             <= 1'b1;
                        state              <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == SETTLE_LAST) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (diff != 9'd0) begin
                        candidates_q <= narrowed;
                        err_count_q  <= err_count_q + 4'd1;
                    end
                    if (k == 3'd7) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        k                 <= k + 3'd1;
                        {i0_q, i1_q, s_q} <= k + 3'd1;
                        cnt               <= 4'd0;
                        state             <= SETTLE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_out      = s_q;
    assign bus.i0_out     = i0_q;
    assign bus.i1_out     = i1_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.candidates = candidates_q;
    assign bus.err_count  = err_count_q;
    assign bus.fault_seen = (err_count_q != 4'd0);

endmodule

// File: tb/tb_mux_fault_diagnoser.sv
// Self-checking bench for mux_fault_diagnoser. A 2:1 mux model, with injectable stuck-at faults, feeds obs.
// A vector-level reference computes the expected diagnosis.
module tb_mux_fault_diagnoser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] sa1 = 9'h000;
    logic [8:0] sa0 = 9'h000;
    int         errors = 0;
    int         checks = 0;

    localparam logic [8:0] W_TABLE [9] = '{9'h100, 9'h080, 9'h040, 9'h060, 9'h050,
                                           9'h058, 9'h0E4, 9'h15A, 9'h1FF};

    always #5 clk = ~clk;

    mux_fault_diagnoser_if bus ();

    mux_fault_diagnoser #(.SETTLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // These are the wires of a healthy 2:1 mux, y = s ? i1 : i0.
    function automatic logic [8:0] mux_wires(input logic s, input logic i0, input logic i1);
        logic [8:0] w;
        w[0] = i0;
        w[1] = i1;
        w[2] = s;
        w[3] = s;
        w[4] = s;
        w[5] = !s;
        w[6] = s && i1;
        w[7] = !s && i0;
        w[8] = s ? i1 : i0;
        return w;
    endfunction

    assign bus.obs = (mux_wires(bus.s_out, bus.i0_out, bus.i1_out) | sa1) & ~sa0;

    // This reference model covers the first nvec vectors of a run.
    function automatic void model(input logic [8:0] f1, input logic [8:0] f0, input int nvec,
                                  output logic [8:0] cand, output int errs);
        logic [8:0] good, diff;
        logic       s, i0, i1;
        int         idx;
        cand = 9'h1FF;
        errs = 0;
        for (int v = 0; v < nvec; v++) begin
            i0   = ((v >> 2) & 1) != 0;
            i1   = ((v >> 1) & 1) != 0;
            s    = (v & 1) != 0;
            good = mux_wires(s, i0, i1);
            diff = ((good | f1) & ~f0) ^ good;
            if (diff != 9'd0) begin
                idx = 0;
                for (int b = 0; b < 9; b++) if (diff[b]) idx = b;
                cand = cand & W_TABLE[idx];
                errs++;
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    // After pulse_start returns, the bench sits at the negedge that follows the start-accepting edge (c = 0).
    task automatic do_run(input string name, input logic [8:0] f1, input logic [8:0] f0, input int poke_at);
        logic [8:0] exp_cand;
        int         exp_err, done_cyc, done_cnt;
        bit         seq_bad;
        logic [2:0] exp_vec;
        model(f1, f0, 8, exp_cand, exp_err);
        sa1 = f1;
        sa0 = f0;
        pulse_start();
        done_cyc = -1;
        done_cnt = 0;
        seq_bad  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            exp_vec = (c < 40) ? 3'(c / 5) : 3'd7;
            if ({bus.i0_out, bus.i1_out, bus.s_out} !== exp_vec || bus.busy !== (c < 40)) seq_bad = 1'b1;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            bus.start = (c == poke_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (done_cyc !== 40) begin
            errors++;
            $display("FAIL %s done_latency: got %0d expected 40", name, done_cyc);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (seq_bad) begin
            errors++;
            $display("FAIL %s drive_busy_sequence: got deviation expected ascending vectors", name);
        end
        checks++;
        if (bus.candidates !== exp_cand) begin
            errors++;
            $display("FAIL %s candidates: got %h expected %h", name, bus.candidates, exp_cand);
        end
        checks++;
        if (bus.err_count !== 4'(exp_err)) begin
            errors++;
            $display("FAIL %s err_count: got %0d expected %0d", name, bus.err_count, exp_err);
        end
        checks++;
        if (bus.fault_seen !== (exp_err != 0)) begin
            errors++;
            $display("FAIL %s fault_seen: got %0b expected %0b", name, bus.fault_seen, exp_err != 0);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.done, bus.fault_seen, bus.s_out, bus.i0_out, bus.i1_out} !== 6'b0 ||
            bus.candidates !== 9'h1FF || bus.err_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b cand=%h err=%0d drv=%b%b%b expected 0 0 1ff 0 000",
                     bus.busy, bus.done, bus.candidates, bus.err_count, bus.i0_out, bus.i1_out, bus.s_out);
        end
    endtask

    task automatic test_fault_free();   do_run("fault_free", 9'h000, 9'h000, -1); endtask
    task automatic test_stuck_obs0();   do_run("obs0_sa1", 9'h001, 9'h000, -1); endtask
    task automatic test_stuck_obs6();   do_run("obs6_sa0", 9'h000, 9'h040, -1); endtask
    task automatic test_double_fault(); do_run("obs8_sa0_obs0_sa1", 9'h001, 9'h100, -1); endtask
    task automatic test_start_ignored(); do_run("start_in_settle", 9'h010, 9'h000, 11); endtask

    task automatic test_start_held();
        int done_cyc;
        sa1 = 9'h001;
        sa0 = 9'h000;
        pulse_start();
        for (int c = 0; c < 43; c++) begin
            if (c == 38) bus.start = 1'b1;
            if (c == 41) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.candidates !== 9'h100) begin
                    errors++;
                    $display("FAIL held_start_idle: got busy=%b done=%b cand=%h expected 0 0 100",
                             bus.busy, bus.done, bus.candidates);
                end
            end
            if (c == 42) begin
                checks++;
                if (bus.busy !== 1'b1 || {bus.i0_out, bus.i1_out, bus.s_out} !== 3'b000 ||
                    bus.candidates !== 9'h1FF || bus.err_count !== 4'd0) begin
                    errors++;
                    $display("FAIL held_start_restart: got busy=%b drv=%b%b%b cand=%h err=%0d expected 1 000 1ff 0",
                             bus.busy, bus.i0_out, bus.i1_out, bus.s_out, bus.candidates, bus.err_count);
                end
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        // At this point, the second run has been under way for one cycle. Its done is due 40 cycles after edge 42.
        done_cyc = -1;
        for (int c = 43; c < 100; c++) begin
            if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c;
            @(negedge clk);
        end
        checks++;
        if (done_cyc !== 82) begin
            errors++;
            $display("FAIL held_start_second_done: got %0d expected 82", done_cyc);
        end
    endtask

    task automatic test_reset_midrun();
        logic [8:0] part_cand;
        int         part_err, done_cnt;
        bit         busy_seen;
        model(9'h008, 9'h000, 5, part_cand, part_err);
        sa1 = 9'h008;
        sa0 = 9'h000;
        pulse_start();
        repeat (27) @(negedge clk);
        checks++;
        if (bus.err_count !== 4'(part_err) || bus.candidates !== part_cand) begin
            errors++;
            $display("FAIL midrun_partial: got err=%0d cand=%h expected %0d %h",
                     bus.err_count, bus.candidates, part_err, part_cand);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.candidates !== 9'h1FF || bus.err_count !== 4'd0 || bus.busy !== 1'b0 ||
            bus.fault_seen !== 1'b0 || {bus.i0_out, bus.i1_out, bus.s_out} !== 3'b000) begin
            errors++;
            $display("FAIL midrun_reset: got cand=%h err=%0d busy=%b fs=%b drv=%b%b%b expected 1ff 0 0 0 000",
                     bus.candidates, bus.err_count, bus.busy, bus.fault_seen, bus.i0_out, bus.i1_out, bus.s_out);
        end
        @(negedge clk) rst_n = 1'b1;
        done_cnt  = 0;
        busy_seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.done === 1'b1) done_cnt++;
            if (bus.busy === 1'b1) busy_seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (done_cnt !== 0 || busy_seen) begin
            errors++;
            $display("FAIL midrun_no_done: got done=%0d busy_seen=%b expected 0 0", done_cnt, busy_seen);
        end
        do_run("after_reset", 9'h000, 9'h000, -1);
    endtask

    task automatic test_random();
        logic [8:0] f1, f0;
        for (int n = 0; n < 6; n++) begin
            f1 = 9'($urandom) & 9'($urandom);
            f0 = 9'($urandom) & 9'($urandom) & ~f1;
            do_run($sformatf("random%0d_sa1_%h_sa0_%h", n, f1, f0), f1, f0, -1);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_fault_free();
        test_stuck_obs0();
        test_stuck_obs6();
        test_double_fault();
        test_start_ignored();
        test_start_held();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_fault_diagnoser.md
Name: mux_fault_diagnoser

Overview:
- Sequential stimulus-and-diagnosis stage wrapped around the 2:1 mux under test (inputs S, I0, I1; 9-bit internal-wire observation vector).
- Drives the mux inputs through all 8 input vectors, waits a settle interval, then samples the mux's 9-bit wire vector and compares it against the golden wire values.
- Narrows a 9-bit candidate-fault mask on each mismatch, and reports the mask and the error count when the run completes.

Parameters:
- SETTLE_CYCLES, 4, cycles the mux inputs are held before sampling `obs` (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a diagnosis run; sampled only in IDLE
- s_out  output  1  drive to mux S
- i0_out  output  1  drive to mux I0
- i1_out  output  1  drive to mux I1
- obs  input  9  observed mux wire vector; bit i = wire i
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at run completion
- candidates  output  9  surviving fault-location mask
- err_count  output  4  number of vectors with any mismatch (0..8)
- fault_seen  output  1  high when err_count != 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - s_out, i0_out and i1_out = 0.
  - busy=0, done=0, candidates=9'h1FF, err_count=0, fault_seen=0, vector counter k=0.
  - Reset mid-run aborts immediately; there is no partial result.
- Vector encoding: k in 0..7; i0_out=k[2], i1_out=k[1], s_out=k[0]. Order is ascending.
- Golden wire vector g[8:0] for the current drive:
  - g0=I0, g1=I1, g2=S, g3=S, g4=S, g5=~S.
  - g6=I1&S, g7=I0&~S, g8=(I1&S)|(I0&~S).
- W table (9-bit constants), indexed by mismatch index:
  - W0=100000000, W1=010000000, W2=001000000.
  - W3=001100000, W4=001010000, W5=001011000.
  - W6=011100100, W7=101011010, W8=111111111.
- State IDLE:
  - On start=1 at an edge: candidates<=1FF, err_count<=0, k<=0, drive vector 0, busy<=1, go to SETTLE with settle counter cnt<=0.
- State SETTLE:
  - cnt increments each edge.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- State SAMPLE (one cycle), at the edge:
  - diff = obs ^ g(k).
  - If diff != 0: idx = index of highest set bit of diff; candidates <= candidates & W[idx]; err_count += 1.
  - If k==7: go to DONE.
  - Otherwise: k<=k+1, drive the new vector, cnt<=0, go to SETTLE.
- State DONE (one cycle): done=1, busy=0; next edge returns to IDLE.
- Hold and ignore rules:
  - candidates and err_count hold until the next accepted start.
  - start is ignored in SETTLE, SAMPLE and DONE.
- Latency: from the start-accepting edge to done high = 8*(SETTLE_CYCLES+1) cycles (40 at default).
- Drive-register behaviour: drive outputs are registered and change only on the start edge or on SAMPLE edges; after the run they keep vector 7 (1,1,1).
- Widths:
  - err_count saturation is unnecessary (max 8 fits in 4 bits).
  - candidates is never reloaded mid-run.
- fault_seen is combinational from err_count.

Test Plan:
- Fault-free mux model (obs = g), default params, start pulse -> done pulse 40 cycles after start edge; candidates=1FF, err_count=0, fault_seen=0; drives end at 1,1,1.
- obs[0] stuck-at-1 -> mismatches at k=0..3, idx=0 each time; final candidates=9'h100, err_count=4, fault_seen=1.
- obs[6] stuck-at-0 -> mismatches at k=3 and k=7, idx=6; final candidates=9'h0E4, err_count=2.
- obs[8] stuck-at-0 and obs[0] stuck-at-1 together:
  - k=0..2: idx=0. k=3: bits 0 and 8 differ, idx=8. k=4, 6, 7: idx=8.
  - Final candidates=9'h100, err_count=7.
- start re-asserted during SETTLE of k=2 -> ignored, run completes normally with the same done timing. start held high through DONE -> new run begins only from IDLE, one cycle after done.
- rst_n pulsed low during k=5 SETTLE after an injected fault -> outputs immediately return to reset values (candidates=1FF, err_count=0, busy=0); no done pulse. A fresh start then completes a full 40-cycle run.
